// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite DMA engine: state encodings and fixed bus constants.
package oam_dma_pkg;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_SYNC  = 3'd1,
        DMA_DUMMY = 3'd2,
        DMA_ALIGN = 3'd3,
        DMA_READ  = 3'd4,
        DMA_WRITE = 3'd5,
        DMA_DONE  = 3'd6
    } dma_state_t;

    // PPU OAM data register; every write of the copy targets it.
    localparam logic [15:0] OAMDATA = 16'h2004;

    // Bytes per transfer. The byte counter is 8 bits, so this cannot change.
    localparam int NBYTES = 256;

    // Counter value of the final byte of a transfer.
    localparam logic [7:0] LAST_BYTE = 8'(NBYTES - 1);

endpackage

// File: rtl/oam_dma_bus_req.sv
// Generic req/ack bus initiator. Latches one access on go and holds it until
// acknowledged. The completion cycle blocks go, so a new request never
// follows a completed one without an idle gap.
module oam_dma_bus_req #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [AW-1:0] addr,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    output logic          dmareq,
    output logic          dmadone,
    output logic [AW-1:0] dmaaddr,
    output logic          dmawr,
    output logic [DW-1:0] dmawdata,
    input  logic          dmaack,
    input  logic [DW-1:0] dmardata,
    output logic [DW-1:0] rdata
);

    // Request register: launch on go, hold the access stable, retire on ack.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmareq   <= 1'b0;
            dmadone  <= 1'b0;
            dmaaddr  <= '0;
            dmawr    <= 1'b0;
            dmawdata <= '0;
            rdata    <= '0;
        end else begin
            dmadone <= 1'b0;
            if (dmareq) begin
                if (dmaack) begin
                    dmareq  <= 1'b0;
                    dmadone <= 1'b1;
                    if (!dmawr) begin
                        rdata <= dmardata;
                    end
                end
            end else if (go && !dmadone) begin
                dmareq   <= 1'b1;
                dmaaddr  <= addr;
                dmawr    <= wr;
                dmawdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/oam_dma.sv
// Sprite DMA engine: halts the CPU on a bus-cycle boundary, performs one or
// two alignment reads, then copies page {page,$00..$FF} into OAMDATA.
module oam_dma
    import oam_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dmastart,
    input  logic [7:0]  dmapage,
    input  logic        cpudone,
    input  logic        cpuodd,
    output logic        halt,
    output logic [15:0] dmaaddr,
    output logic [7:0]  dmawdata,
    output logic        dmawr,
    output logic        dmareq,
    input  logic        dmaack,
    input  logic [7:0]  dmardata,
    output logic        dmadone,
    output logic        busy
);

    dma_state_t  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        odd_q, odd_d;
    logic        halt_d, busy_d;
    logic        go;
    logic [15:0] req_addr;
    logic        req_wr;
    logic [7:0]  rdata;

    oam_dma_bus_req #(.AW(16), .DW(8)) u_bus_req (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .addr     (req_addr),
        .wr       (req_wr),
        .wdata    (rdata),
        .dmareq   (dmareq),
        .dmadone  (dmadone),
        .dmaaddr  (dmaaddr),
        .dmawr    (dmawr),
        .dmawdata (dmawdata),
        .dmaack   (dmaack),
        .dmardata (dmardata),
        .rdata    (rdata)
    );

    // Next-state, next register values and the access presented to the initiator.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        cnt_d    = cnt_q;
        odd_d    = odd_q;
        halt_d   = halt;
        busy_d   = busy;
        go       = 1'b0;
        req_addr = {page_q, 8'h00};
        req_wr   = 1'b0;
        case (state_q)
            DMA_IDLE: begin
                if (dmastart) begin
                    page_d  = dmapage;
                    busy_d  = 1'b1;
                    cnt_d   = 8'h00;
                    state_d = DMA_SYNC;
                end
            end
            DMA_SYNC: begin
                // Only a CPU cycle boundary may stop the CPU.
                if (cpudone) begin
                    halt_d  = 1'b1;
                    odd_d   = cpuodd;
                    state_d = DMA_DUMMY;
                end
            end
            DMA_DUMMY: begin
                go = 1'b1;
                if (dmadone) begin
                    state_d = odd_q ? DMA_ALIGN : DMA_READ;
                end
            end
            DMA_ALIGN: begin
                go = 1'b1;
                if (dmadone) begin
                    state_d = DMA_READ;
                end
            end
            DMA_READ: begin
                go       = 1'b1;
                req_addr = {page_q, cnt_q};
                if (dmadone) begin
                    state_d = DMA_WRITE;
                end
            end
            DMA_WRITE: begin
                go       = 1'b1;
                req_addr = OAMDATA;
                req_wr   = 1'b1;
                if (dmadone) begin
                    if (cnt_q == LAST_BYTE) begin
                        // Release the CPU in the cycle right after the last write completes.
                        halt_d  = 1'b0;
                        busy_d  = 1'b0;
                        state_d = DMA_DONE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = DMA_READ;
                    end
                end
            end
            DMA_DONE: begin
                state_d = DMA_IDLE;
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    // State, page latch, byte counter, parity and the registered halt/busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            page_q  <= 8'h00;
            cnt_q   <= 8'h00;
            odd_q   <= 1'b0;
            halt    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            cnt_q   <= cnt_d;
            odd_q   <= odd_d;
            halt    <= halt_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a memory responder model acks requests and
// a scoreboard of expected accesses is filled at each transfer start.
module tb_oam_dma;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmastart;
    logic [7:0]  dmapage;
    logic        cpudone;
    logic        cpuodd;
    logic        halt;
    logic [15:0] dmaaddr;
    logic [7:0]  dmawdata;
    logic        dmawr;
    logic        dmareq;
    logic        dmaack;
    logic [7:0]  dmardata;
    logic        dmadone;
    logic        busy;

    acc_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_cnt  = 0;
    int   ack_delay = 3;

    oam_dma dut (
        .clk      (clk),
        .rst      (rst),
        .dmastart (dmastart),
        .dmapage  (dmapage),
        .cpudone  (cpudone),
        .cpuodd   (cpuodd),
        .halt     (halt),
        .dmaaddr  (dmaaddr),
        .dmawdata (dmawdata),
        .dmawr    (dmawr),
        .dmareq   (dmareq),
        .dmaack   (dmaack),
        .dmardata (dmardata),
        .dmadone  (dmadone),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // RAM contents seen by the responder; page $02 gives $0200+i = i^$5A.
    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h58;
    endfunction

    function automatic void push_acc(input logic wr, input logic [15:0] addr, input logic [7:0] data);
        acc_t e;
        e.wr   = wr;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endfunction

    // dmadone pulse counter.
    initial begin
        forever begin
            @(negedge clk);
            if (dmadone) done_cnt++;
        end
    end

    // Memory responder: acks ack_delay cycles after req rises, checks the handshake and the scoreboard.
    initial begin
        acc_t        e;
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
        bit          aborted;
        int          low_cnt;
        dmaack   = 1'b0;
        dmardata = 8'h00;
        low_cnt  = 1;
        forever begin
            @(negedge clk);
            if (rst || !dmareq) begin
                low_cnt++;
                continue;
            end
            check("req_gap", 32'(low_cnt >= 1), 32'd1);
            low_cnt = 0;
            a       = dmaaddr;
            w       = dmawr;
            d       = dmawdata;
            aborted = 1'b0;
            for (int k = 1; k < ack_delay; k++) begin
                @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                check("req_hold", 32'(dmareq), 32'd1);
                check("addr_hold", 32'(dmaaddr), 32'(a));
                check("wr_hold", 32'(dmawr), 32'(w));
                check("wdata_hold", 32'(dmawdata), 32'(d));
            end
            if (aborted) begin
                low_cnt = 1;
                continue;
            end
            dmardata = w ? 8'h00 : ram_byte(a);
            dmaack   = 1'b1;
            @(negedge clk);
            dmaack   = 1'b0;
            dmardata = 8'h00;
            low_cnt  = 1;
            check("req_drop", 32'(dmareq), 32'd0);
            check("done_pulse", 32'(dmadone), 32'd1);
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("acc_wr", 32'(w), 32'(e.wr));
                check("acc_addr", 32'(a), 32'(e.addr));
                if (e.wr) check("acc_wdata", 32'(d), 32'(e.data));
                if (e.wr && sb.size() == 0) begin
                    check("halt_last_done", 32'(halt), 32'd1);
                    @(negedge clk);
                    low_cnt++;
                    check("halt_release", 32'(halt), 32'd0);
                    check("busy_release", 32'(busy), 32'd0);
                end
            end
        end
    end

    // Start a transfer, then produce the sync cpudone with the requested parity.
    task automatic start_transfer(input logic [7:0] page, input logic odd, input logic coincide);
        push_acc(1'b0, {page, 8'h00}, 8'h00);
        if (odd) push_acc(1'b0, {page, 8'h00}, 8'h00);
        for (int i = 0; i < 256; i++) begin
            push_acc(1'b0, {page, 8'(i)}, 8'h00);
            push_acc(1'b1, 16'h2004, ram_byte({page, 8'(i)}));
        end
        done_cnt = 0;
        dmastart = 1'b1;
        dmapage  = page;
        cpudone  = coincide;
        cpuodd   = ~odd;
        @(negedge clk);
        dmastart = 1'b0;
        dmapage  = 8'h00;
        cpudone  = 1'b0;
        repeat (3) @(negedge clk);
        check("halt_presync", 32'(halt), 32'd0);
        check("busy_start", 32'(busy), 32'd1);
        check("req_presync", 32'(dmareq), 32'd0);
        cpudone = 1'b1;
        cpuodd  = odd;
        @(negedge clk);
        cpudone = 1'b0;
        cpuodd  = ~odd;
        check("halt_sync", 32'(halt), 32'd1);
    endtask

    task automatic finish_transfer(input int exp_done);
        int i = 0;
        while (busy && i < 20000) begin
            @(negedge clk);
            i++;
        end
        check("busy_timeout", 32'(busy), 32'd0);
        check("dmadone_count", 32'(done_cnt), 32'(exp_done));
        check("sb_drained", 32'(sb.size()), 32'd0);
        repeat (4) @(negedge clk);
        check("idle_halt", 32'(halt), 32'd0);
        check("idle_req", 32'(dmareq), 32'd0);
    endtask

    task automatic wait_req(input logic [15:0] a);
        int i = 0;
        while (!(dmareq && dmaaddr == a) && i < 20000) begin
            @(negedge clk);
            i++;
        end
        check("wait_req", 32'(dmareq && dmaaddr == a), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        dmastart = 1'b0;
        dmapage  = 8'h00;
        cpudone  = 1'b0;
        cpuodd   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_req", 32'(dmareq), 32'd0);
        check("rst_wr", 32'(dmawr), 32'd0);
        check("rst_addr", 32'(dmaaddr), 32'd0);
        check("rst_wdata", 32'(dmawdata), 32'd0);
        check("rst_done", 32'(dmadone), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset during byte 100, then a fresh transfer must start at byte 0.
        start_transfer(8'h04, 1'b0, 1'b0);
        wait_req(16'h0464);
        rst = 1'b1;
        @(negedge clk);
        check("abort_halt", 32'(halt), 32'd0);
        check("abort_req", 32'(dmareq), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_transfer(8'h05, 1'b0, 1'b0);
        finish_transfer(513);

        // Even transfer from page $02; a cpudone coinciding with dmastart is not consumed.
        start_transfer(8'h02, 1'b0, 1'b1);
        finish_transfer(513);

        // Odd alignment adds one dummy read.
        start_transfer(8'h02, 1'b1, 1'b0);
        finish_transfer(514);

        // Fastest and slow responders.
        ack_delay = 1;
        start_transfer(8'h11, 1'b0, 1'b0);
        finish_transfer(513);
        ack_delay = 7;
        start_transfer(8'h3C, 1'b1, 1'b0);
        finish_transfer(514);
        ack_delay = 3;

        // Top page must not wrap into $0000.
        start_transfer(8'hFF, 1'b0, 1'b0);
        finish_transfer(513);

        // Retrigger at byte 10 is ignored.
        start_transfer(8'h03, 1'b0, 1'b0);
        wait_req(16'h030A);
        dmastart = 1'b1;
        dmapage  = 8'h07;
        @(negedge clk);
        dmastart = 1'b0;
        dmapage  = 8'h00;
        finish_transfer(513);
        repeat (20) @(negedge clk);
        check("retrigger_busy", 32'(busy), 32'd0);
        check("retrigger_done", 32'(done_cnt), 32'd513);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
